// File: rtl/cbuf_pkg.sv
// Shared sizing helpers and parameter legality checks for the circular-buffer controller.
package cbuf_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned par_write,
                                   input int unsigned par_read);
    return (depth >= 2) && (depth <= 1024) &&
           (par_write >= 1) && (par_write <= depth) &&
           (par_read >= 1) && (par_read <= depth);
  endfunction

endpackage

// File: rtl/cbuf_ptr.sv
// Modular pointer register: advances by STEP modulo DEPTH on enable, synchronous clear.
module cbuf_ptr
  import cbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned STEP  = 1,
  localparam int unsigned W    = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);

  localparam logic [W:0] STEP_C  = (W+1)'(STEP);
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);

  logic [W:0] ptr_q;
  logic [W:0] sum;
  logic [W:0] wrapped;

  // ptr_q < DEPTH and STEP <= DEPTH, so one conditional subtract suffices
  always_comb begin
    sum     = ptr_q + STEP_C;
    wrapped = (sum >= DEPTH_C) ? (sum - DEPTH_C) : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr_q <= '0;
    else if (clr) ptr_q <= '0;
    else if (en)  ptr_q <= wrapped;
  end

  assign ptr = ptr_q[W-1:0];

endmodule

// File: rtl/cbuf_ctrl.sv
// Circular-buffer controller: occupancy, pointers and error flags for an external memory.
module cbuf_ctrl
  import cbuf_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAR_WRITE = 1,
  parameter int unsigned PAR_READ  = 1,
  localparam int unsigned ADDR_W   = clog2(DEPTH),
  localparam int unsigned CNT_W    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              write_en,
  input  logic              read_en,
  output logic              ready,
  output logic              valid,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              udf_err
);

  if (!params_ok(DEPTH, PAR_WRITE, PAR_READ)) begin : g_param_err
    $error("cbuf_ctrl: DEPTH/PAR_WRITE/PAR_READ out of legal range");
  end

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0] PW_C    = (CNT_W+1)'(PAR_WRITE);
  localparam logic [CNT_W:0] PR_C    = (CNT_W+1)'(PAR_READ);

  logic             wr_fire;
  logic             rd_fire;
  logic [CNT_W:0]   cnt_q;
  logic [CNT_W:0]   cnt_nxt;

  // ready/valid look only at the registered count, so both sides may fire together
  assign ready = (DEPTH_C - cnt_q) >= PW_C;
  assign valid = cnt_q >= PR_C;
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign count = cnt_q[CNT_W-1:0];

  // rst also masks the fires so a write strobe never leaks out during reset
  assign wr_fire = write_en & ready & ~flush & ~rst;
  assign rd_fire = read_en  & valid & ~flush & ~rst;
  assign wen     = wr_fire;

  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_fire) cnt_nxt = cnt_nxt + PW_C;
    if (rd_fire) cnt_nxt = cnt_nxt - PR_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (flush) begin
      cnt_q   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (write_en && !ready) ovf_err <= 1'b1;
      if (read_en  && !valid) udf_err <= 1'b1;
    end
  end

  cbuf_ptr #(.DEPTH(DEPTH), .STEP(PAR_WRITE)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (wr_fire),
    .ptr (waddr)
  );

  cbuf_ptr #(.DEPTH(DEPTH), .STEP(PAR_READ)) u_rptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (rd_fire),
    .ptr (raddr)
  );

endmodule

// File: tb/tb_cbuf_ctrl.sv
// Self-checking bench for cbuf_ctrl: directed and random steps against a queue-based occupancy model.
module tb_cbuf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, write_en, read_en;
  logic       ready, valid, wen, full, empty, ovf_err, udf_err;
  logic [2:0] waddr, raddr;
  logic [3:0] count;

  logic       flush6, we6, re6;
  logic       ready6, valid6, wen6, full6, empty6, ovf6, udf6;
  logic [2:0] waddr6, raddr6;
  logic [2:0] count6;

  int vectors    = 0;
  int miscompares = 0;

  // reference model: occupied addresses in arrival order, plus plain integer pointers
  int q[$];
  int m_wp, m_rp;
  bit m_ovf, m_udf;

  always #5 clk = ~clk;

  cbuf_ctrl #(.DEPTH(8), .PAR_WRITE(3), .PAR_READ(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .read_en(read_en),
    .ready(ready), .valid(valid), .wen(wen), .waddr(waddr), .raddr(raddr),
    .count(count), .full(full), .empty(empty), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  cbuf_ctrl #(.DEPTH(6), .PAR_WRITE(4), .PAR_READ(2)) dut6 (
    .clk(clk), .rst(rst), .flush(flush6), .write_en(we6), .read_en(re6),
    .ready(ready6), .valid(valid6), .wen(wen6), .waddr(waddr6), .raddr(raddr6),
    .count(count6), .full(full6), .empty(empty6), .ovf_err(ovf6), .udf_err(udf6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic chk_state(input string tag);
    int c;
    bit mr, mv;
    c  = q.size();
    mr = (8 - c) >= 3;
    mv = c >= 2;
    chk({tag, ".count"}, count, c);
    chk({tag, ".ready"}, ready, mr);
    chk({tag, ".valid"}, valid, mv);
    chk({tag, ".full"},  full,  c == 8);
    chk({tag, ".empty"}, empty, c == 0);
    chk({tag, ".waddr"}, waddr, m_wp);
    chk({tag, ".raddr"}, raddr, m_rp);
    chk({tag, ".ovf"},   ovf_err, m_ovf);
    chk({tag, ".udf"},   udf_err, m_udf);
    chk({tag, ".wen"},   wen, write_en & mr & ~flush & ~rst);
  endtask

  task automatic step(input string tag, input bit we, input bit re, input bit fl);
    int c;
    bit mr, mv, wf, rf;
    write_en = we; read_en = re; flush = fl;
    #3;
    chk_state(tag);
    c  = q.size();
    mr = (8 - c) >= 3;
    mv = c >= 2;
    wf = we && mr && !fl;
    rf = re && mv && !fl;
    @(posedge clk); #1;
    if (fl) model_reset();
    else begin
      if (rf) begin
        repeat (2) void'(q.pop_front());
        m_rp = (m_rp + 2) % 8;
      end
      if (wf) begin
        for (int k = 0; k < 3; k++) q.push_back((m_wp + k) % 8);
        m_wp = (m_wp + 3) % 8;
      end
      if (we && !mr) m_ovf = 1;
      if (re && !mv) m_udf = 1;
    end
  endtask

  task automatic step6(input string tag, input bit we, input bit re,
                       input int e_wen, input int e_waddr, input int e_count);
    we6 = we; re6 = re;
    #3;
    chk({tag, ".wen6"},   wen6, e_wen);
    chk({tag, ".waddr6"}, waddr6, e_waddr);
    chk({tag, ".count6"}, count6, e_count);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; write_en = 1'b0; read_en = 1'b0;
    flush6 = 1'b0; we6 = 1'b0; re6 = 1'b0;
    model_reset();
    #12;
    chk("rst.count", count, 0);
    chk("rst.ready", ready, 1);
    chk("rst.valid", valid, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full",  full, 0);
    chk("rst.wen",   wen, 0);
    chk("rst.waddr", waddr, 0);
    chk("rst.raddr", raddr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // three writes: 3, 6, then refused with overflow
    step("w1", 1, 0, 0);
    step("w2", 1, 0, 0);
    step("w3", 1, 0, 0);
    chk("w3.ovf_set", ovf_err, 1);
    chk("w3.count6", count, 6);
    // drain then wrap-around write
    step("r1", 0, 1, 0);
    step("r2", 0, 1, 0);
    step("r3", 0, 1, 0);
    chk("drain.raddr", raddr, 6);
    step("wwrap", 1, 0, 0);
    chk("wwrap.waddr", waddr, 1);
    chk("wwrap.count", count, 3);
    // build count 4, then simultaneous read and write
    step("r4", 0, 1, 0);
    step("w4", 1, 0, 0);
    step("both", 1, 1, 0);
    chk("both.count", count, 5);
    // flush with write pending
    step("flush", 1, 0, 1);
    chk("flush.count", count, 0);
    chk("flush.ovf", ovf_err, 0);

    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom % 2), 1'($urandom % 2), ($urandom % 16) == 0);

    // reach count 5, then asynchronous reset between edges with fires requested
    step("pre_f", 0, 0, 1);
    step("pre_w", 1, 0, 0);
    step("pre_b1", 1, 1, 0);
    step("pre_b2", 1, 1, 0);
    chk("pre.count5", count, 5);
    write_en = 1'b1; read_en = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk_state("midrst");
    #1;
    rst = 1'b0;
    step("postrst", 1, 1, 0);
    step("idle", 0, 0, 0);

    // DEPTH=6, PAR_WRITE=4 wrap sequence
    step6("d6.w0", 1, 0, 1, 0, 0);
    we6 = 1'b1; #3;
    chk("d6.ready_part", ready6, 0);
    step6("d6.r0", 0, 1, 0, 4, 4);
    step6("d6.r1", 0, 1, 0, 4, 2);
    step6("d6.w1", 1, 0, 1, 4, 0);
    step6("d6.r2", 0, 1, 0, 2, 4);
    step6("d6.r3", 0, 1, 0, 2, 2);
    step6("d6.w2", 1, 0, 1, 2, 0);
    step6("d6.idle", 0, 0, 0, 0, 4);
    chk("d6.raddr", raddr6, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
